// File: rtl/text_console_ctrl.sv
// Write-port controller for the VGA text RAM: places characters at a wrapping
// cursor and runs a full-screen clear, sharing one byte-wide write port.
module text_console_ctrl #(
  parameter int COLS = 30,
  parameter int ROWS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        put_valid,
  output logic        put_ready,
  input  logic [7:0]  put_char,
  input  logic [7:0]  put_attr,
  input  logic        clr_req,
  input  logic [7:0]  clr_attr,
  output logic        busy,
  output logic [4:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        ram_cea,
  output logic [10:0] ram_ada,
  output logic [7:0]  ram_din
);

  typedef enum logic [2:0] {IDLE, PUT_CHR, PUT_ATR, CLR_CHR, CLR_ATR} state_t;

  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  state_t     state;
  logic       pending;
  logic       run;
  logic [7:0] attr_q;
  logic [4:0] clr_col, clr_row;
  logic [4:0] clr_col_nxt, clr_row_nxt;
  logic [4:0] cur_col_nxt, cur_row_nxt;
  logic [4:0] row_inc;
  logic       clr_last;
  logic       clr_start;
  logic       accept;

  // run keeps put_ready low while reset is held and for the first edge after it
  assign put_ready = run && (state == IDLE) && !pending;
  assign busy      = (state != IDLE) || pending;
  assign accept    = put_valid && put_ready;

  always_comb begin
    row_inc     = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
    cur_col_nxt = cur_col + 5'd1;
    cur_row_nxt = cur_row;
    if (cur_col == LAST_COL) begin
      cur_col_nxt = 5'd0;
      cur_row_nxt = row_inc;
    end
    clr_last    = (clr_col == LAST_COL) && (clr_row == LAST_ROW);
    clr_col_nxt = clr_col + 5'd1;
    clr_row_nxt = clr_row;
    if (clr_col == LAST_COL) begin
      clr_col_nxt = 5'd0;
      clr_row_nxt = clr_row + 5'd1;
    end
  end

  // A pending clear is served at every point where the write port becomes free
  assign clr_start = pending &&
                     ((state == IDLE) || (state == PUT_ATR) ||
                      ((state == CLR_ATR) && clr_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      run     <= 1'b0;
      attr_q  <= 8'd0;
      clr_col <= 5'd0;
      clr_row <= 5'd0;
      cur_col <= 5'd0;
      cur_row <= 5'd0;
      ram_cea <= 1'b0;
      ram_ada <= 11'd0;
      ram_din <= 8'd0;
    end else begin
      run <= 1'b1;
      if (clr_req) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            case (put_char)
              CH_CR: cur_col <= 5'd0;
              CH_LF: cur_row <= row_inc;
              CH_BS: if (cur_col != 5'd0) cur_col <= cur_col - 5'd1;
              default: begin
                attr_q  <= put_attr;
                ram_cea <= 1'b1;
                ram_ada <= {cur_row, cur_col, 1'b0};
                ram_din <= put_char;
                state   <= PUT_CHR;
              end
            endcase
          end
        end
        PUT_CHR: begin
          ram_ada <= ram_ada + 11'd1;
          ram_din <= attr_q;
          state   <= PUT_ATR;
        end
        PUT_ATR: begin
          cur_col <= cur_col_nxt;
          cur_row <= cur_row_nxt;
          ram_cea <= 1'b0;
          state   <= IDLE;
        end
        CLR_CHR: begin
          ram_ada <= ram_ada + 11'd1;
          ram_din <= attr_q;
          state   <= CLR_ATR;
        end
        CLR_ATR: begin
          if (clr_last) begin
            cur_col <= 5'd0;
            cur_row <= 5'd0;
            ram_cea <= 1'b0;
            state   <= IDLE;
          end else begin
            clr_col <= clr_col_nxt;
            clr_row <= clr_row_nxt;
            ram_ada <= {clr_row_nxt, clr_col_nxt, 1'b0};
            ram_din <= SPACE;
            state   <= CLR_CHR;
          end
        end
        default: begin
          ram_cea <= 1'b0;
          state   <= IDLE;
        end
      endcase

      // Overrides the case above; a request arriving on this very edge re-arms pending
      if (clr_start) begin
        pending <= clr_req;
        attr_q  <= clr_attr;
        clr_col <= 5'd0;
        clr_row <= 5'd0;
        ram_cea <= 1'b1;
        ram_ada <= 11'd0;
        ram_din <= SPACE;
        state   <= CLR_CHR;
      end
    end
  end

endmodule
